// File: rtl/calculator_muehlbb_if.sv
// Pin bundle of the calculator tile: op select, operand stream, result stream
// and the bidirectional pin controls.
interface calculator_muehlbb_if;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (
      output ena, ui_in, uio_in,
      input  uo_out, uio_out, uio_oe
   );

   modport slave (
      input  ena, ui_in, uio_in,
      output uo_out, uio_out, uio_oe
   );
endinterface

// File: rtl/calculator_muehlbb.sv
// Byte-serial 16-bit ALU tile: an 8-phase free-running sequencer loads A and B,
// computes on phase 4 and streams result lo, result hi and flags on phases 5..7.
module calculator_muehlbb (
   input  logic                  clk,
   input  logic                  rst_n,
   calculator_muehlbb_if.slave   bus
);

   logic [2:0]  phase_q, phase_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [15:0] result_q, result_d;
   logic [7:0]  flags_q, flags_d;

   logic [15:0] alu_res;
   logic        alu_c;
   logic        alu_v;

   logic signed [15:0] a_s;
   logic signed [15:0] b_s;
   logic [16:0] sum17;
   logic [16:0] dif17;
   logic [31:0] prod;
   logic [31:0] rot;
   logic [3:0]  sh;
   logic        v_add;
   logic        v_sub;

   // A saturated result always clamps toward the sign of A: overflow on add
   // needs equal signs, and overflow on sub needs A's sign opposite to B's.
   function automatic logic [15:0] sat16(input logic [15:0] raw,
                                         input logic        ovf,
                                         input logic        a_sign);
      if (!ovf)
         return raw;
      return a_sign ? 16'h8000 : 16'h7FFF;
   endfunction

   assign a_s   = a_q;
   assign b_s   = b_q;
   assign sh    = b_q[3:0];
   assign sum17 = {1'b0, a_q} + {1'b0, b_q};
   assign dif17 = {1'b0, a_q} - {1'b0, b_q};
   assign prod  = {16'h0000, a_q} * {16'h0000, b_q};
   assign rot   = {a_q, a_q} << sh;
   assign v_add = (a_q[15] == b_q[15]) && (sum17[15] != a_q[15]);
   assign v_sub = (a_q[15] != b_q[15]) && (dif17[15] != a_q[15]);

   always_comb begin
      alu_res = 16'h0000;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      unique case (bus.ui_in[3:0])
         4'd0:  begin alu_res = sum17[15:0]; alu_c = sum17[16]; alu_v = v_add; end
         4'd1:  begin alu_res = dif17[15:0]; alu_c = dif17[16]; alu_v = v_sub; end
         4'd2:  alu_res = prod[15:0];
         4'd3:  alu_res = a_q & b_q;
         4'd4:  alu_res = a_q | b_q;
         4'd5:  alu_res = a_q ^ b_q;
         4'd6:  alu_res = ~a_q;
         4'd7:  alu_res = 16'h0000 - a_q;
         4'd8:  alu_res = a_q << sh;
         4'd9:  alu_res = a_q >> sh;
         4'd10: alu_res = a_s >>> sh;
         4'd11: alu_res = rot[31:16];
         4'd12: begin
            alu_res = sat16(sum17[15:0], v_add, a_q[15]);
            alu_c   = sum17[16];
            alu_v   = v_add;
         end
         4'd13: begin
            alu_res = sat16(dif17[15:0], v_sub, a_q[15]);
            alu_c   = dif17[16];
            alu_v   = v_sub;
         end
         4'd14: alu_res = {15'b0, (a_s < b_s)};
         4'd15: alu_res = (a_q > b_q) ? a_q : b_q;
         default: alu_res = 16'h0000;
      endcase
   end

   always_comb begin
      phase_d  = phase_q + 3'd1;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      flags_d  = flags_q;
      case (phase_q)
         3'd0: a_d[7:0]  = bus.uio_in;
         3'd1: a_d[15:8] = bus.uio_in;
         3'd2: b_d[7:0]  = bus.uio_in;
         3'd3: b_d[15:8] = bus.uio_in;
         3'd4: begin
            result_d = alu_res;
            flags_d  = {4'b0000, alu_v, alu_res[15], alu_c, (alu_res == 16'h0000)};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q  <= 3'd0;
         a_q      <= 16'h0000;
         b_q      <= 16'h0000;
         result_q <= 16'h0000;
         flags_q  <= 8'h00;
      end else begin
         phase_q  <= phase_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   always_comb begin
      case (phase_q)
         3'd5:    bus.uo_out = result_q[7:0];
         3'd6:    bus.uo_out = result_q[15:8];
         3'd7:    bus.uo_out = flags_q;
         default: bus.uo_out = 8'h00;
      endcase
   end

   assign bus.uio_out = 8'h00;
   assign bus.uio_oe  = 8'h00;

   logic unused_bits;
   assign unused_bits = &{1'b0, bus.ena, bus.ui_in[7:4], prod[31:16], rot[15:0]};

endmodule

// File: tb/tb_calculator_muehlbb.sv
// Directed bench for the byte-serial calculator tile: streams operand pairs,
// checks the three result bytes, the idle zeros and a mid-sequence reset.
module tb_calculator_muehlbb;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   calculator_muehlbb_if bus ();

   calculator_muehlbb dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Entered at a falling edge with the sequencer in phase 0; leaves at the
   // falling edge of the next phase 0. The op is only valid during phase 4.
   task automatic run_op(input string tag, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_res, input logic [7:0] exp_flags);
      logic [7:0] bytes [4];
      bytes[0] = a[7:0];
      bytes[1] = a[15:8];
      bytes[2] = b[7:0];
      bytes[3] = b[15:8];
      for (int p = 0; p < 8; p++) begin
         bus.ena    = 1'($urandom_range(0, 1));
         bus.ui_in  = (p == 4) ? {4'h0, op} : {4'($urandom), ~op};
         bus.uio_in = (p < 4) ? bytes[p] : 8'($urandom);
         #1;
         if (p == 5)      check({tag, " lo"}, bus.uo_out, exp_res[7:0]);
         else if (p == 6) check({tag, " hi"}, bus.uo_out, exp_res[15:8]);
         else if (p == 7) check({tag, " flags"}, bus.uo_out, exp_flags);
         else if (p == 0) check({tag, " idle"}, bus.uo_out, 8'h00);
         if (p == 3) begin
            check({tag, " uio_out"}, bus.uio_out, 8'h00);
            check({tag, " uio_oe"}, bus.uio_oe, 8'h00);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      rst_n      = 1'b0;
      bus.ena    = 1'b0;
      bus.ui_in  = 8'h00;
      bus.uio_in = 8'h00;
      repeat (2) @(negedge clk);
      check("reset uo_out", bus.uo_out, 8'h00);
      check("reset uio_oe", bus.uio_oe, 8'h00);
      rst_n = 1'b1;

      run_op("add_carry", 4'd0,  16'hFFFF, 16'h0001, 16'h0000, 8'h03);
      run_op("sadd_mix",  4'd12, 16'h4000, 16'h8000, 16'hC000, 8'h04);
      run_op("ssub_sat",  4'd13, 16'h4000, 16'h8000, 16'h7FFF, 8'h0A);
      run_op("mul",       4'd2,  16'h0100, 16'h0101, 16'h0100, 8'h00);
      run_op("asr",       4'd10, 16'h8000, 16'h0004, 16'hF800, 8'h04);
      run_op("sub_brw",   4'd1,  16'h0003, 16'h0005, 16'hFFFE, 8'h06);
      run_op("rol",       4'd11, 16'h8001, 16'h0001, 16'h0003, 8'h00);
      run_op("shl_zero",  4'd8,  16'h0001, 16'h0010, 16'h0001, 8'h00);
      run_op("shr",       4'd9,  16'h8000, 16'h000F, 16'h0001, 8'h00);
      run_op("slt",       4'd14, 16'h8000, 16'h0001, 16'h0001, 8'h00);
      run_op("maxu",      4'd15, 16'h8000, 16'h7FFF, 16'h8000, 8'h04);
      run_op("sadd_sat",  4'd12, 16'h7FFF, 16'h0001, 16'h7FFF, 8'h08);
      run_op("xor_zero",  4'd5,  16'hAAAA, 16'hAAAA, 16'h0000, 8'h01);
      run_op("neg",       4'd7,  16'h0001, 16'h0000, 16'hFFFF, 8'h04);
      run_op("not",       4'd6,  16'h00FF, 16'h1234, 16'hFF00, 8'h04);
      run_op("add_ovf",   4'd0,  16'h7FFF, 16'h0001, 16'h8000, 8'h0C);
      run_op("and",       4'd3,  16'hF0F0, 16'h3C3C, 16'h3030, 8'h00);
      run_op("or",        4'd4,  16'hF000, 16'h000F, 16'hF00F, 8'h04);

      // Abort a sequence after A has been loaded; the tile must restart at
      // phase 0 and take the next bytes as a fresh A.
      bus.uio_in = 8'h12;
      @(negedge clk);
      bus.uio_in = 8'h34;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst uo_out", bus.uo_out, 8'h00);
      @(negedge clk);
      check("midrst hold", bus.uo_out, 8'h00);
      rst_n = 1'b1;
      run_op("post_rst",  4'd0,  16'h1111, 16'h2222, 16'h3333, 8'h00);
      run_op("post_rst2", 4'd1,  16'h8000, 16'h0001, 16'h7FFF, 8'h08);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "bench timed out");
   end

endmodule
